// File: rtl/ex_stage.sv
// ex_stage: RISC-V execute stage (ALU, branch resolve, EX/MEM register); optional iterative multiplier via EX_MUL_EN
module ex_stage #(
  parameter int XLEN        = 32,
  parameter int PC_SIZE     = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        read_data1,
  input  logic [XLEN-1:0]        read_data2,
  input  logic [XLEN-1:0]        imm,
  input  logic [XLEN-1:0]        lui_imm,
  input  logic [PC_SIZE-1:0]     bxx_imm,
  input  logic [PC_SIZE-1:0]     pc,
  input  logic [3:0]             alu_funct,
  input  logic [2:0]             bxx_funct,
  input  logic [1:0]             ex_alu_op,
  input  logic [RFIDX_WIDTH-1:0] rd_index,
  input  logic [2:0]             m_mem_mode,
  input  logic                   ex_branch,
  input  logic                   ex_add2_sel,
  input  logic                   ex_pc_sel,
  input  logic                   ex_lui_sel,
  input  logic                   m_mem_read,
  input  logic                   m_mem_write,
  input  logic                   wb_reg_write,
  input  logic                   wb_memtoreg,
  input  logic                   mem_stall,
  output logic                   ex_stall,
  output logic                   redirect_valid,
  output logic [PC_SIZE-1:0]     redirect_pc,
  output logic                   ex_valid_out,
  output logic [XLEN-1:0]        alu_result_out,
  output logic [XLEN-1:0]        store_data_out,
  output logic [RFIDX_WIDTH-1:0] rd_index_out,
  output logic [2:0]             m_mem_mode_out,
  output logic                   m_mem_read_out,
  output logic                   m_mem_write_out,
  output logic                   wb_reg_write_out,
  output logic                   wb_memtoreg_out
);
  logic [XLEN-1:0]    w_op_a, w_op_b, w_alu, w_base, w_result;
  logic [4:0]         w_shamt;
  logic [PC_SIZE-1:0] w_target;
  logic               w_taken, w_live, w_mul_busy;

  assign w_op_a   = ex_pc_sel ? XLEN'(pc) : read_data1;
  assign w_op_b   = ex_add2_sel ? imm : read_data2;
  assign w_shamt  = w_op_b[4:0];
  assign w_target = pc + bxx_imm;
  assign w_base   = ex_lui_sel ? lui_imm :
                    (ex_branch && bxx_funct == 3'b010) ? XLEN'(pc + PC_SIZE'(4)) : w_alu;

  // ALU: add unless the R/I-type class decodes another function
  always_comb begin
    w_alu = w_op_a + w_op_b;
    if (ex_alu_op == 2'b10)
      case (alu_funct)
        4'b1000: w_alu = w_op_a - w_op_b;
        4'b0001: w_alu = w_op_a << w_shamt;
        4'b0010: w_alu = XLEN'($signed(w_op_a) < $signed(w_op_b));
        4'b0011: w_alu = XLEN'(w_op_a < w_op_b);
        4'b0100: w_alu = w_op_a ^ w_op_b;
        4'b0101: w_alu = w_op_a >> w_shamt;
        4'b1101: w_alu = $signed(w_op_a) >>> w_shamt;
        4'b0110: w_alu = w_op_a | w_op_b;
        4'b0111: w_alu = w_op_a & w_op_b;
        default: ;
      endcase
  end

  // Branch condition always compares the register operands, never the immediate
  always_comb begin
    case (bxx_funct)
      3'b000:  w_taken = read_data1 == read_data2;
      3'b001:  w_taken = read_data1 != read_data2;
      3'b010:  w_taken = 1'b1;
      3'b100:  w_taken = $signed(read_data1) < $signed(read_data2);
      3'b101:  w_taken = $signed(read_data1) >= $signed(read_data2);
      3'b110:  w_taken = read_data1 < read_data2;
      3'b111:  w_taken = read_data1 >= read_data2;
      default: w_taken = 1'b0;
    endcase
  end

`ifdef EX_MUL_EN
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_mplier;
  logic [2*XLEN-1:0]   r_mcand, r_acc;
  logic                r_hi;
  logic                w_mul_req;

  // A multiply presented in the redirect shadow is wrong-path and must not start
  assign w_mul_req  = in_valid && ex_alu_op == 2'b11 && !redirect_valid;
  assign w_mul_busy = (r_state == S_IDLE && w_mul_req) || r_state == S_BUSY;
  assign w_result   = r_state == S_DONE ? (r_hi ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0]) : w_base;

  // Shift-add multiplier: one multiplier bit per BUSY cycle, result held in DONE until MEM accepts it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_hi     <= 1'b0;
    end else
      case (r_state)
        S_IDLE: if (w_mul_req) begin
          r_state  <= S_BUSY;
          r_cnt    <= '0;
          r_mplier <= w_op_b;
          r_mcand  <= {{XLEN{1'b0}}, w_op_a};
          r_acc    <= '0;
          r_hi     <= alu_funct[2:0] == 3'b011;
        end
        S_BUSY: begin
          r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_DONE;
        end
        default: if (!mem_stall) r_state <= S_IDLE;
      endcase
`else
  assign w_mul_busy = 1'b0;
  assign w_result   = w_base;
`endif

  assign ex_stall = mem_stall | w_mul_busy;
  assign w_live   = in_valid && !ex_stall && !redirect_valid;

  // EX/MEM and redirect registers; wrong-path or bubble slots carry zeroed controls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid_out     <= 1'b0;
      alu_result_out   <= '0;
      store_data_out   <= '0;
      rd_index_out     <= '0;
      m_mem_mode_out   <= '0;
      m_mem_read_out   <= 1'b0;
      m_mem_write_out  <= 1'b0;
      wb_reg_write_out <= 1'b0;
      wb_memtoreg_out  <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
    end else if (!mem_stall) begin
      ex_valid_out     <= w_live;
      alu_result_out   <= w_result;
      store_data_out   <= read_data2;
      rd_index_out     <= w_live ? rd_index : '0;
      m_mem_mode_out   <= w_live ? m_mem_mode : '0;
      m_mem_read_out   <= w_live & m_mem_read;
      m_mem_write_out  <= w_live & m_mem_write;
      wb_reg_write_out <= w_live & wb_reg_write;
      wb_memtoreg_out  <= w_live & wb_memtoreg;
      redirect_valid   <= w_live & ex_branch & w_taken;
      if (w_live && ex_branch && w_taken) redirect_pc <= w_target;
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage (multiplier scenario runs only with EX_MUL_EN)
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] read_data1, read_data2, imm, lui_imm, bxx_imm, pc;
  logic [3:0]  alu_funct;
  logic [2:0]  bxx_funct;
  logic [1:0]  ex_alu_op;
  logic [4:0]  rd_index;
  logic [2:0]  m_mem_mode;
  logic        ex_branch, ex_add2_sel, ex_pc_sel, ex_lui_sel;
  logic        m_mem_read, m_mem_write, wb_reg_write, wb_memtoreg, mem_stall;
  logic        ex_stall, redirect_valid, ex_valid_out;
  logic [31:0] redirect_pc, alu_result_out, store_data_out;
  logic [4:0]  rd_index_out;
  logic [2:0]  m_mem_mode_out;
  logic        m_mem_read_out, m_mem_write_out, wb_reg_write_out, wb_memtoreg_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic        cr;
    logic        wb;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .read_data1(read_data1), .read_data2(read_data2), .imm(imm), .lui_imm(lui_imm),
    .bxx_imm(bxx_imm), .pc(pc), .alu_funct(alu_funct), .bxx_funct(bxx_funct),
    .ex_alu_op(ex_alu_op), .rd_index(rd_index), .m_mem_mode(m_mem_mode),
    .ex_branch(ex_branch), .ex_add2_sel(ex_add2_sel), .ex_pc_sel(ex_pc_sel), .ex_lui_sel(ex_lui_sel),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write), .wb_reg_write(wb_reg_write),
    .wb_memtoreg(wb_memtoreg), .mem_stall(mem_stall), .ex_stall(ex_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ex_valid_out(ex_valid_out),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_index_out(rd_index_out),
    .m_mem_mode_out(m_mem_mode_out), .m_mem_read_out(m_mem_read_out), .m_mem_write_out(m_mem_write_out),
    .wb_reg_write_out(wb_reg_write_out), .wb_memtoreg_out(wb_memtoreg_out)
  );

  task automatic idle_in();
    in_valid = 0; read_data1 = 0; read_data2 = 0; imm = 0; lui_imm = 0; bxx_imm = 0; pc = 0;
    alu_funct = 0; bxx_funct = 0; ex_alu_op = 0; rd_index = 0; m_mem_mode = 0;
    ex_branch = 0; ex_add2_sel = 0; ex_pc_sel = 0; ex_lui_sel = 0;
    m_mem_read = 0; m_mem_write = 0; wb_reg_write = 0; wb_memtoreg = 0; mem_stall = 0;
  endtask

  task automatic set_addi(input logic [31:0] a, input logic [31:0] i);
    idle_in();
    in_valid = 1; ex_alu_op = 2'b10; read_data1 = a; ex_add2_sel = 1; imm = i; wb_reg_write = 1; rd_index = 5'd1;
  endtask

  task automatic set_br(input logic [2:0] f, input logic [31:0] p, input logic [31:0] off,
                        input logic [31:0] a, input logic [31:0] b);
    idle_in();
    in_valid = 1; ex_branch = 1; ex_alu_op = 2'b01; bxx_funct = f; pc = p; bxx_imm = off;
    read_data1 = a; read_data2 = b;
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    rst_n = 0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    outs = {ex_valid_out, redirect_valid, redirect_pc, alu_result_out, store_data_out, rd_index_out,
            m_mem_mode_out, m_mem_read_out, m_mem_write_out, wb_reg_write_out, wb_memtoreg_out, ex_stall};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", outs); end
    @(negedge clk);
    rst_n = 1;
    set_addi(32'd20, 32'd22);
    read_data2 = 32'h55; m_mem_mode = 3'b010; m_mem_read = 1; wb_memtoreg = 1;
    @(posedge clk); #1;
    checks++;
    if (ex_valid_out !== 1'b1 || alu_result_out !== 32'd42 || m_mem_mode_out !== 3'b010 || wb_memtoreg_out !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_instr got v=%b res=%h mode=%b m2r=%b want v=1 res=0000002a mode=010 m2r=1",
               ex_valid_out, alu_result_out, m_mem_mode_out, wb_memtoreg_out);
    end
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    outs = {ex_valid_out, redirect_valid, redirect_pc, alu_result_out, store_data_out, rd_index_out,
            m_mem_mode_out, m_mem_read_out, m_mem_write_out, wb_reg_write_out, wb_memtoreg_out, 1'b0};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL midstream_reset got=%h want=0", outs); end
    @(negedge clk);
    rst_n = 1;
    set_addi(32'd5, 32'd3);
    sbq.push_back('{1'b1, 32'd8, 1'b1, 1'b1, 1'b0, 32'd0});
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++;
    if (ex_valid_out !== e.v || alu_result_out !== e.res || rd_index_out !== 5'd1 || wb_reg_write_out !== e.wb) begin
      failures++;
      $display("FAIL first_addi got v=%b res=%h rd=%0d wb=%b want v=%b res=%h rd=1 wb=%b",
               ex_valid_out, alu_result_out, rd_index_out, wb_reg_write_out, e.v, e.res, e.wb);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  fn [11] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                             4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001};
    logic [31:0] xr [11] = '{32'h80000001, 32'h7FFFFFFF, 32'h00000000, 32'h00000001, 32'h00000000,
                             32'h80000001, 32'h40000000, 32'hC0000000, 32'h80000001, 32'h00000000,
                             32'h80000001};
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      idle_in();
      in_valid = 1; wb_reg_write = 1; rd_index = 5'd3; ex_alu_op = 2'b10;
      if (i < 11) begin
        alu_funct = fn[i]; read_data1 = 32'h80000000; read_data2 = 32'd1;
        sbq.push_back('{1'b1, xr[i], 1'b1, 1'b1, 1'b0, 32'd0});
      end else if (i == 11) begin
        ex_alu_op = 2'b00; ex_add2_sel = 1; read_data1 = 32'h1000; imm = 32'h10; read_data2 = 32'hDEAD;
        sbq.push_back('{1'b1, 32'h1010, 1'b1, 1'b1, 1'b0, 32'd0});
      end else if (i == 12) begin
        ex_lui_sel = 1; lui_imm = 32'hABCDE000; read_data1 = 32'd1; read_data2 = 32'hDEAD;
        sbq.push_back('{1'b1, 32'hABCDE000, 1'b1, 1'b1, 1'b0, 32'd0});
      end else if (i == 13) begin
        ex_alu_op = 2'b00; ex_pc_sel = 1; ex_add2_sel = 1; pc = 32'h400; imm = 32'h8; read_data2 = 32'hDEAD;
        sbq.push_back('{1'b1, 32'h408, 1'b1, 1'b1, 1'b0, 32'd0});
      end else begin
        in_valid = 0;
        sbq.push_back('{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0});
      end
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if (ex_valid_out !== e.v || wb_reg_write_out !== e.wb || (e.cr && alu_result_out !== e.res)) begin
        failures++;
        $display("FAIL alu_%0d got v=%b wb=%b res=%h want v=%b wb=%b res=%h",
                 i, ex_valid_out, wb_reg_write_out, alu_result_out, e.v, e.wb, e.res);
      end
      if (i >= 11 && i <= 13) begin
        checks++;
        if (store_data_out !== 32'hDEAD) begin
          failures++; $display("FAIL store_data_%0d got=%h want=0000dead", i, store_data_out);
        end
      end
    end
  endtask

  typedef struct {
    int          k;
    logic [2:0]  f;
    logic [31:0] pc, off, a, b;
    logic        v, rv, cr;
    logic [31:0] rpc, res;
  } brow_t;

  task automatic test_branch();
    brow_t rows [14] = '{
      '{1, 3'b000, 32'h100, 32'h20, 32'd5,        32'd5,        1'b1, 1'b1, 1'b0, 32'h120, 32'd0},
      '{0, 3'b000, 32'h0,   32'h0,  32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 32'h0,   32'd0},
      '{0, 3'b000, 32'h0,   32'h0,  32'd0,        32'd0,        1'b1, 1'b0, 1'b1, 32'h0,   32'd8},
      '{1, 3'b001, 32'h200, 32'h8,  32'd5,        32'd5,        1'b1, 1'b0, 1'b0, 32'h0,   32'd0},
      '{1, 3'b010, 32'h300, 32'h80, 32'd0,        32'd0,        1'b1, 1'b1, 1'b1, 32'h380, 32'h304},
      '{0, 3'b000, 32'h0,   32'h0,  32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 32'h0,   32'd0},
      '{1, 3'b100, 32'h500, 32'h10, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b1, 1'b0, 32'h510, 32'd0},
      '{0, 3'b000, 32'h0,   32'h0,  32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 32'h0,   32'd0},
      '{1, 3'b110, 32'h500, 32'h10, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 1'b0, 32'h0,   32'd0},
      '{1, 3'b011, 32'h500, 32'h10, 32'd5,        32'd5,        1'b1, 1'b0, 1'b0, 32'h0,   32'd0},
      '{1, 3'b101, 32'h600, 32'h4,  32'd1,        32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h604, 32'd0},
      '{1, 3'b111, 32'h700, 32'h4,  32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 32'h0,   32'd0},
      '{1, 3'b111, 32'h700, 32'h4,  32'd5,        32'd5,        1'b1, 1'b1, 1'b0, 32'h704, 32'd0},
      '{2, 3'b000, 32'h0,   32'h0,  32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 32'h0,   32'd0}
    };
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (rows[i].k == 0) set_addi(32'd5, 32'd3);
      else if (rows[i].k == 1) set_br(rows[i].f, rows[i].pc, rows[i].off, rows[i].a, rows[i].b);
      else idle_in();
      sbq.push_back('{rows[i].v, rows[i].res, rows[i].cr, rows[i].k == 0 && rows[i].v, rows[i].rv, rows[i].rpc});
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if (ex_valid_out !== e.v || wb_reg_write_out !== e.wb) begin
        failures++;
        $display("FAIL br_valid_%0d got v=%b wb=%b want v=%b wb=%b", i, ex_valid_out, wb_reg_write_out, e.v, e.wb);
      end
      checks++;
      if (redirect_valid !== e.rv || (e.rv && redirect_pc !== e.rpc)) begin
        failures++;
        $display("FAIL br_redirect_%0d got rv=%b pc=%h want rv=%b pc=%h", i, redirect_valid, redirect_pc, e.rv, e.rpc);
      end
      if (e.cr) begin
        checks++;
        if (alu_result_out !== e.res) begin
          failures++; $display("FAIL br_result_%0d got=%h want=%h", i, alu_result_out, e.res);
        end
      end
    end
  endtask

  task automatic test_stall();
    int pulses = 0;
    @(negedge clk);
    set_addi(32'd5, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    set_br(3'b001, 32'h200, 32'h40, 32'd1, 32'd2);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ex_stall !== 1'b1) begin failures++; $display("FAIL stall_ex_stall_%0d got=%b want=1", i, ex_stall); end
      @(posedge clk); #1;
      checks++;
      if (redirect_valid !== 1'b0 || ex_valid_out !== 1'b1 || alu_result_out !== 32'd8) begin
        failures++;
        $display("FAIL stall_hold_%0d got rv=%b v=%b res=%h want rv=0 v=1 res=00000008",
                 i, redirect_valid, ex_valid_out, alu_result_out);
      end
      @(negedge clk);
    end
    mem_stall = 0;
    sbq.push_back('{1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 32'h240});
    #1;
    checks++;
    if (ex_stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%b want=0", ex_stall); end
    @(posedge clk); #1;
    e = sbq.pop_front();
    if (redirect_valid) pulses++;
    checks++;
    if (ex_valid_out !== e.v || redirect_valid !== e.rv || redirect_pc !== e.rpc) begin
      failures++;
      $display("FAIL stall_redirect got v=%b rv=%b pc=%h want v=%b rv=%b pc=%h",
               ex_valid_out, redirect_valid, redirect_pc, e.v, e.rv, e.rpc);
    end
    @(negedge clk);
    idle_in();
    @(posedge clk); #1;
    if (redirect_valid) pulses++;
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL stall_pulse_count got=%0d want=1", pulses); end
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int stall_cnt, done_cyc;
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      idle_in();
      in_valid = 1; ex_alu_op = 2'b11; alu_funct = (m == 0) ? 4'b0011 : 4'b0000;
      read_data1 = 32'hFFFFFFFF; read_data2 = 32'd2; wb_reg_write = 1; rd_index = 5'd7;
      sbq.push_back('{1'b1, (m == 0) ? 32'h00000001 : 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 32'd0});
      stall_cnt = 0;
      done_cyc = 0;
      for (int c = 0; c < 100 && done_cyc == 0; c++) begin
        #1;
        if (ex_stall) stall_cnt++;
        @(posedge clk); #1;
        if (ex_valid_out) done_cyc = c + 1;
        else @(negedge clk);
      end
      e = sbq.pop_front();
      checks++;
      if (stall_cnt !== 33) begin failures++; $display("FAIL mul%0d_stall_cycles got=%0d want=33", m, stall_cnt); end
      checks++;
      if (done_cyc !== 34) begin failures++; $display("FAIL mul%0d_latency got=%0d want=34", m, done_cyc); end
      checks++;
      if (alu_result_out !== e.res || wb_reg_write_out !== e.wb) begin
        failures++;
        $display("FAIL mul%0d_result got res=%h wb=%b want res=%h wb=%b", m, alu_result_out, wb_reg_write_out, e.res, e.wb);
      end
      @(negedge clk);
      idle_in();
      @(posedge clk); #1;
      checks++;
      if (ex_valid_out !== 1'b0) begin failures++; $display("FAIL mul%0d_single_issue got v=%b want 0", m, ex_valid_out); end
    end
  endtask
`else
  task automatic test_nomul();
    @(negedge clk);
    idle_in();
    in_valid = 1; ex_alu_op = 2'b11; read_data1 = 32'd7; read_data2 = 32'd9; wb_reg_write = 1; rd_index = 5'd2;
    sbq.push_back('{1'b1, 32'd16, 1'b1, 1'b1, 1'b0, 32'd0});
    #1;
    checks++;
    if (ex_stall !== 1'b0) begin failures++; $display("FAIL nomul_stall got=%b want=0", ex_stall); end
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++;
    if (ex_valid_out !== e.v || alu_result_out !== e.res) begin
      failures++;
      $display("FAIL nomul_result got v=%b res=%h want v=%b res=%h", ex_valid_out, alu_result_out, e.v, e.res);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_stall();
`ifdef EX_MUL_EN
    test_mul();
`else
    test_nomul();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
